// File: rtl/src_sched_if.sv
// Handshake bundle between the source DMA / compute engine and src_sched.
// The slave modport is the scheduler's view; the master modport is the environment's.
interface src_sched_if #(
    parameter int unsigned WORDS = 16
);
    localparam int unsigned AW = $clog2(WORDS);

    logic          run;
    logic          src_valid;
    logic          src_last;
    logic          src_ready;
    logic          wr_bank;
    logic [AW-1:0] wr_addr;
    logic [1:0]    src_en;
    logic          p;
    logic [AW:0]   s_len;
    logic          s_init;
    logic          s_fin;
    logic          dst_ready;
    logic          s_fin_in;
    logic          done;
    logic [15:0]   commit_cnt;
    logic [15:0]   stall_cnt;

    modport slave (
        input  run, src_valid, src_last, s_fin, dst_ready,
        output src_ready, wr_bank, wr_addr, src_en, p, s_len, s_init, s_fin_in, done,
               commit_cnt, stall_cnt
    );

    modport master (
        output run, src_valid, src_last, s_fin, dst_ready,
        input  src_ready, wr_bank, wr_addr, src_en, p, s_len, s_init, s_fin_in, done,
               commit_cnt, stall_cnt
    );
endinterface

// File: rtl/src_sched.sv
// Ping-pong source bank scheduler: fills two banks from a DMA stream and hands them to compute.
// Optional counters: define SRC_SCHED_STATS_EN to enable commit_cnt / stall_cnt.
module src_sched #(
    parameter int unsigned WORDS = 16
) (
    input logic        clk,
    input logic        rst,
    src_sched_if.slave bus
);
    localparam int unsigned AW = $clog2(WORDS);

    typedef enum logic [1:0] {StIdle, StBusy, StHold, StDone} state_e;

    state_e        state_q, state_d;
    logic          p_q, p_d;
    logic          wr_bank_q, wr_bank_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [1:0]    src_en_q, src_en_d;
    logic [AW:0]   len_q [2];
    logic [AW:0]   len_d [2];
    logic          last_seen_q, last_seen_d;
    logic          last_bank_q, last_bank_d;
    logic          s_init_q, s_init_d;
    logic          accept, fill, commit;

    assign accept = bus.src_ready & bus.src_valid;
    assign fill   = accept & ((wr_addr_q == AW'(WORDS - 1)) | bus.src_last);
    // Gated by run so an abandoned job never reports a commit.
    assign commit = bus.run & bus.dst_ready &
                    (((state_q == StBusy) & bus.s_fin) | (state_q == StHold));

    always_comb begin
        state_d     = state_q;
        p_d         = p_q;
        wr_bank_d   = wr_bank_q;
        wr_addr_d   = wr_addr_q;
        src_en_d    = src_en_q;
        len_d       = len_q;
        last_seen_d = last_seen_q;
        last_bank_d = last_bank_q;
        s_init_d    = 1'b0;

        if (accept) begin
            wr_addr_d = wr_addr_q + AW'(1);
            if (bus.src_last) begin
                last_seen_d = 1'b1;
                last_bank_d = wr_bank_q;
            end
            if (fill) begin
                src_en_d[wr_bank_q] = 1'b1;
                len_d[wr_bank_q]    = (AW+1)'(wr_addr_q) + (AW+1)'(1);
                wr_bank_d           = ~wr_bank_q;
                wr_addr_d           = '0;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (src_en_q[p_q]) begin
                    state_d  = StBusy;
                    s_init_d = 1'b1;
                end
            end
            StBusy: begin
                if (bus.s_fin & ~bus.dst_ready) state_d = StHold;
            end
            StHold: state_d = StHold;
            StDone: state_d = StDone;
            default: state_d = StIdle;
        endcase

        if (commit) begin
            src_en_d[p_q] = 1'b0;
            p_d           = ~p_q;
            // Look at src_en_d so a bank completing this very cycle starts without an idle gap.
            if (last_seen_q & (p_q == last_bank_q)) begin
                state_d = StDone;
            end else if (src_en_d[~p_q]) begin
                state_d  = StBusy;
                s_init_d = 1'b1;
            end else begin
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            p_q         <= 1'b0;
            wr_bank_q   <= 1'b0;
            wr_addr_q   <= '0;
            src_en_q    <= 2'b00;
            len_q[0]    <= '0;
            len_q[1]    <= '0;
            last_seen_q <= 1'b0;
            last_bank_q <= 1'b0;
            s_init_q    <= 1'b0;
        end else if (!bus.run) begin
            state_q     <= StIdle;
            p_q         <= 1'b0;
            wr_bank_q   <= 1'b0;
            wr_addr_q   <= '0;
            src_en_q    <= 2'b00;
            len_q[0]    <= '0;
            len_q[1]    <= '0;
            last_seen_q <= 1'b0;
            last_bank_q <= 1'b0;
            s_init_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            p_q         <= p_d;
            wr_bank_q   <= wr_bank_d;
            wr_addr_q   <= wr_addr_d;
            src_en_q    <= src_en_d;
            len_q       <= len_d;
            last_seen_q <= last_seen_d;
            last_bank_q <= last_bank_d;
            s_init_q    <= s_init_d;
        end
    end

    assign bus.src_ready = bus.run & ~src_en_q[wr_bank_q] & ~last_seen_q;
    assign bus.wr_bank   = wr_bank_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.src_en    = src_en_q;
    assign bus.p         = p_q;
    assign bus.s_len     = len_q[p_q];
    assign bus.s_init    = s_init_q;
    assign bus.s_fin_in  = commit;
    assign bus.done      = (state_q == StDone);

`ifdef SRC_SCHED_STATS_EN
    logic [15:0] commit_cnt_q, stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            commit_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else if (!bus.run) begin
            commit_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            if (commit && (commit_cnt_q != 16'hFFFF)) commit_cnt_q <= commit_cnt_q + 16'd1;
            if ((state_q == StHold) && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign bus.commit_cnt = commit_cnt_q;
    assign bus.stall_cnt  = stall_cnt_q;
`else
    assign bus.commit_cnt = 16'd0;
    assign bus.stall_cnt  = 16'd0;
`endif
endmodule

// File: tb/tb_src_sched.sv
// Directed bench for src_sched with WORDS=4; counter expectations follow SRC_SCHED_STATS_EN.
module tb_src_sched;
`ifdef SRC_SCHED_STATS_EN
    localparam bit Stats = 1'b1;
`else
    localparam bit Stats = 1'b0;
`endif

    logic        clk;
    logic        rst;
    int unsigned n_checks;
    int unsigned n_pass;

    src_sched_if #(.WORDS(4)) bus ();

    src_sched #(.WORDS(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drop run for one edge to clear the block, then re-enable with quiet inputs.
    task automatic restart();
        bus.run       = 1'b0;
        bus.src_valid = 1'b0;
        bus.src_last  = 1'b0;
        bus.s_fin     = 1'b0;
        bus.dst_ready = 1'b1;
        tick();
        bus.run = 1'b1;
    endtask

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        rst           = 1'b1;
        bus.run       = 1'b0;
        bus.src_valid = 1'b0;
        bus.src_last  = 1'b0;
        bus.s_fin     = 1'b0;
        bus.dst_ready = 1'b0;
        repeat (2) tick();
        check("rst_src_ready", 32'(bus.src_ready), 0);
        check("rst_src_en", 32'(bus.src_en), 0);
        check("rst_wr_addr", 32'(bus.wr_addr), 0);
        check("rst_p", 32'(bus.p), 0);
        check("rst_s_len", 32'(bus.s_len), 0);
        check("rst_s_init", 32'(bus.s_init), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_commit_cnt", 32'(bus.commit_cnt), 0);

        // Eight words, last on word 8, compute finishes 3 cycles after each s_init.
        rst           = 1'b0;
        bus.run       = 1'b1;
        bus.src_valid = 1'b1;
        bus.dst_ready = 1'b1;
        #1;
        check("s1_src_ready", 32'(bus.src_ready), 1);
        repeat (3) tick();
        check("s1_addr3", 32'(bus.wr_addr), 3);
        check("s1_en_pre", 32'(bus.src_en), 0);
        tick();
        check("s1_en_b0", 32'(bus.src_en), 1);
        check("s1_wr_bank", 32'(bus.wr_bank), 1);
        check("s1_wr_addr0", 32'(bus.wr_addr), 0);
        check("s1_no_init_yet", 32'(bus.s_init), 0);
        tick();
        check("s1_init0", 32'(bus.s_init), 1);
        check("s1_len0", 32'(bus.s_len), 4);
        check("s1_p0", 32'(bus.p), 0);
        tick();
        check("s1_init_once", 32'(bus.s_init), 0);
        tick();
        bus.src_last = 1'b1;
        #1;
        check("s1_ready_last", 32'(bus.src_ready), 1);
        tick();
        bus.src_valid = 1'b0;
        bus.src_last  = 1'b0;
        bus.s_fin     = 1'b1;
        #1;
        check("s1_en_both", 32'(bus.src_en), 3);
        check("s1_ready_lo", 32'(bus.src_ready), 0);
        check("s1_commit0", 32'(bus.s_fin_in), 1);
        tick();
        bus.s_fin = 1'b0;
        #1;
        check("s1_p1", 32'(bus.p), 1);
        check("s1_en_10", 32'(bus.src_en), 2);
        check("s1_init1", 32'(bus.s_init), 1);
        check("s1_len1", 32'(bus.s_len), 4);
        check("s1_not_done", 32'(bus.done), 0);
        check("s1_ready_lastseen", 32'(bus.src_ready), 0);
        repeat (3) tick();
        bus.s_fin = 1'b1;
        #1;
        check("s1_commit1", 32'(bus.s_fin_in), 1);
        tick();
        bus.s_fin = 1'b0;
        #1;
        check("s1_done", 32'(bus.done), 1);
        check("s1_p_back", 32'(bus.p), 0);
        check("s1_en_clear", 32'(bus.src_en), 0);
        check("s1_commit_cnt", 32'(bus.commit_cnt), Stats ? 2 : 0);
        tick();
        check("s1_done_held", 32'(bus.done), 1);
        check("s1_done_no_init", 32'(bus.s_init), 0);

        // Six words, last on word 6: bank1 holds 2 words and done waits for its commit.
        restart();
        check("s2_cleared_done", 32'(bus.done), 0);
        bus.src_valid = 1'b1;
        repeat (5) tick();
        bus.src_last = 1'b1;
        #1;
        check("s2_init0", 32'(bus.s_init), 1);
        tick();
        bus.src_valid = 1'b0;
        bus.src_last  = 1'b0;
        bus.s_fin     = 1'b1;
        #1;
        check("s2_en_both", 32'(bus.src_en), 3);
        check("s2_ready_lo", 32'(bus.src_ready), 0);
        check("s2_wr_bank", 32'(bus.wr_bank), 0);
        check("s2_commit0", 32'(bus.s_fin_in), 1);
        tick();
        bus.s_fin = 1'b0;
        #1;
        check("s2_p1", 32'(bus.p), 1);
        check("s2_len_short", 32'(bus.s_len), 2);
        check("s2_init1", 32'(bus.s_init), 1);
        check("s2_not_done", 32'(bus.done), 0);
        tick();
        bus.s_fin = 1'b1;
        #1;
        check("s2_commit1", 32'(bus.s_fin_in), 1);
        tick();
        bus.s_fin = 1'b0;
        #1;
        check("s2_done", 32'(bus.done), 1);
        check("s2_en_clear", 32'(bus.src_en), 0);
        check("s2_commit_cnt", 32'(bus.commit_cnt), Stats ? 2 : 0);

        // Both banks full, dst side blocked: five HOLD cycles before the commit.
        restart();
        bus.src_valid = 1'b1;
        repeat (8) tick();
        bus.src_valid = 1'b0;
        bus.s_fin     = 1'b1;
        bus.dst_ready = 1'b0;
        #1;
        check("s3_en_both", 32'(bus.src_en), 3);
        check("s3_no_commit", 32'(bus.s_fin_in), 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            bus.s_fin = (i == 1);
            #1;
            check("s3_hold_ready", 32'(bus.src_ready), 0);
            check("s3_hold_fin_in", 32'(bus.s_fin_in), 0);
            tick();
        end
        bus.s_fin     = 1'b0;
        bus.dst_ready = 1'b1;
        #1;
        check("s3_commit", 32'(bus.s_fin_in), 1);
        check("s3_ready_commit", 32'(bus.src_ready), 0);
        tick();
        check("s3_stall_cnt", 32'(bus.stall_cnt), Stats ? 5 : 0);
        check("s3_p1", 32'(bus.p), 1);
        check("s3_init1", 32'(bus.s_init), 1);
        check("s3_en_10", 32'(bus.src_en), 2);
        check("s3_ready_again", 32'(bus.src_ready), 1);

        // Commit of bank0 coincides with bank1 filling.
        restart();
        bus.src_valid = 1'b1;
        repeat (7) tick();
        bus.s_fin = 1'b1;
        #1;
        check("s4_en_01", 32'(bus.src_en), 1);
        check("s4_commit", 32'(bus.s_fin_in), 1);
        check("s4_ready", 32'(bus.src_ready), 1);
        tick();
        bus.s_fin     = 1'b0;
        bus.src_valid = 1'b0;
        #1;
        check("s4_en_10", 32'(bus.src_en), 2);
        check("s4_p1", 32'(bus.p), 1);
        check("s4_init", 32'(bus.s_init), 1);
        check("s4_len", 32'(bus.s_len), 4);

        // run dropped while BUSY.
        bus.run = 1'b0;
        tick();
        check("s5_init", 32'(bus.s_init), 0);
        check("s5_p", 32'(bus.p), 0);
        check("s5_en", 32'(bus.src_en), 0);
        check("s5_wr_bank", 32'(bus.wr_bank), 0);
        check("s5_wr_addr", 32'(bus.wr_addr), 0);
        check("s5_s_len", 32'(bus.s_len), 0);
        check("s5_fin_in", 32'(bus.s_fin_in), 0);
        check("s5_done", 32'(bus.done), 0);
        bus.run = 1'b1;
        #1;
        check("s5_ready_back", 32'(bus.src_ready), 1);
        tick();
        check("s5_no_init", 32'(bus.s_init), 0);

        // Asynchronous reset in the middle of a fill.
        bus.src_valid = 1'b1;
        repeat (2) tick();
        check("s6_addr2", 32'(bus.wr_addr), 2);
        #2;
        rst = 1'b1;
        #1;
        check("s6_async_addr", 32'(bus.wr_addr), 0);
        check("s6_async_bank", 32'(bus.wr_bank), 0);
        bus.src_valid = 1'b0;
        rst           = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/src_sched.md
SRC_SCHED -- requirements
Module: src_sched

Interface
REQ-001 Parameter WORDS, default 16: words per source bank; legal range 2..256. AW = clog2(WORDS).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 run  in  1  job enable; low = synchronous clear to reset values.
REQ-005 src_valid  in  1  word strobe from source DMA.
REQ-006 src_last  in  1  qualifies src_valid; final word of job.
REQ-007 src_ready  out  1  word accepted when src_valid & src_ready.
REQ-008 wr_bank  out  1  bank being filled.
REQ-009 wr_addr  out  AW  word address within wr_bank.
REQ-010 src_en  out  2  per-bank full flags.
REQ-011 p  out  1  bank owned by compute.
REQ-012 s_len  out  AW+1  word count of bank p.
REQ-013 s_init  out  1  one-cycle compute start pulse.
REQ-014 s_fin  in  1  compute done; results in dst buffer.
REQ-015 dst_ready  in  1  dst side may accept results.
REQ-016 s_fin_in  out  1  combinational commit pulse; releases bank p.
REQ-017 done  out  1  job complete, held.
REQ-018 commit_cnt  out  16  commits since run rose.
REQ-019 stall_cnt  out  16  cycles spent in HOLD.

Function
REQ-020 src_ready SHALL equal run & ~src_en[wr_bank] & ~last_seen.
REQ-021 Each accepted word SHALL increment wr_addr; at WORDS-1, or with src_last, the block SHALL set src_en[wr_bank], store count (wr_addr+1) in len[wr_bank], toggle wr_bank, and clear wr_addr.
REQ-022 Accepting src_last SHALL set last_seen and record last_bank = wr_bank; src_ready stays low until run falls.
REQ-023 Compute FSM states: IDLE, BUSY, HOLD, DONE.
REQ-024 IDLE: src_en[p]=1 -> BUSY, with s_init high for exactly the first BUSY cycle.
REQ-025 BUSY: s_fin & dst_ready -> commit; s_fin & ~dst_ready -> HOLD; otherwise stay.
REQ-026 HOLD: dst_ready -> commit; otherwise stay; s_fin ignored.
REQ-027 s_fin_in SHALL be 1 exactly in the commit cycle: (BUSY & s_fin | HOLD) & dst_ready.
REQ-028 Commit SHALL clear src_en[p] and toggle p.
REQ-029 Commit state change: last_seen & p==last_bank -> DONE; else src_en[~p] -> BUSY with s_init pulse; else -> IDLE.
REQ-030 DONE: done=1, s_init=0, s_fin_in=0 until run falls.
REQ-031 Fill-set and commit-clear in one cycle always hit different banks; both SHALL take effect.
REQ-032 s_len SHALL equal len[p] combinationally.
REQ-033 Latency: bank-full edge to s_init = 1 cycle when IDLE; commit to next s_init = 1 cycle when the other bank is full.

Reset
REQ-034 rst high or run low SHALL clear: FSM=IDLE, p=0, wr_bank=0, wr_addr=0, src_en=00, len=0, last_seen=0, last_bank=0, s_init=0, done=0, commit_cnt=0, stall_cnt=0.
REQ-035 Reset or run low mid-job SHALL abandon the job; no s_init or s_fin_in pulse in the following cycle.

Configuration
REQ-036 With SRC_SCHED_STATS_EN defined: commit_cnt increments per s_fin_in, stall_cnt increments per HOLD cycle, both saturate at 16'hFFFF.
REQ-037 Without SRC_SCHED_STATS_EN: both ports remain present and are tied to 0; no counter registers exist.

Verification
REQ-038 WORDS=4, 8 words streamed, dst_ready=1, s_fin 3 cycles after each s_init -> two s_init pulses, p goes 0->1->0, s_len=4 each time, done=1 after second commit, commit_cnt=2.
REQ-039 6 words with src_last on word 6 -> bank1 has len=2, last_bank=1, done only after the bank1 commit.
REQ-040 Both banks full, dst_ready=0 at s_fin for 5 cycles -> HOLD for 5 cycles, s_fin_in in the cycle dst_ready rises, stall_cnt=5 (0 without macro), src_ready low throughout.
REQ-041 Commit of bank0 in the same cycle bank1 fills -> src_en 01->10, next-cycle s_init, p=1.
REQ-042 run dropped during BUSY -> next cycle all outputs at reset values; rst pulse mid-fill -> immediate async clear.
